// File: rtl/video_ts_render.sv
// Tile/sprite renderer: fetches 4bpp graphics words for one render task
// and writes the non-transparent pixels into the TS line buffer.
module video_ts_render (
  input  logic        clk,
  input  logic        rst,
  input  logic        tsr_go,
  input  logic [5:0]  tsr_addr,
  input  logic [8:0]  tsr_line,
  input  logic [7:0]  tsr_page,
  input  logic [8:0]  tsr_x,
  input  logic [2:0]  tsr_xs,
  input  logic        tsr_xf,
  input  logic [3:0]  tsr_pal,
  output logic        tsr_rdy,
  output logic [20:0] dram_addr,
  output logic        dram_req,
  input  logic        dram_next,
  input  logic [15:0] dram_rdata,
  output logic [8:0]  lbuf_addr,
  output logic [7:0]  lbuf_data,
  output logic        lbuf_we
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [8:0]  line_q, line_d;
  logic [6:0]  w_q, w_d;
  logic        xf_q, xf_d;
  logic [3:0]  pal_q, pal_d;
  logic [4:0]  wl_q, wl_d;
  logic [6:0]  pl_q, pl_d;
  logic [8:0]  x_q, x_d;
  logic [15:0] s_q, s_d;
  logic [2:0]  sc_q, sc_d;
  logic [15:0] p_q, p_d;
  logic        pv_q, pv_d;

  logic        run;
  logic        grant;
  logic        emit;
  logic        s_free;
  logic [3:0]  pix;
  logic [3:0]  span;
  logic [15:0] seq;

  // Word re-ordered so the first pixel to emit sits in the top nibble.
  always_comb begin
    if (xf_q)
      seq = {dram_rdata[11:8], dram_rdata[15:12],
             dram_rdata[3:0], dram_rdata[7:4]};
    else
      seq = {dram_rdata[7:0], dram_rdata[15:8]};
  end

  always_comb begin
    run      = (state_q == RUN);
    dram_req = run && (wl_q != 5'd0) && !pv_q;
    grant    = dram_req && dram_next;
    emit     = run && (sc_q != 3'd0);
    s_free   = (sc_q == 3'd0) || (sc_q == 3'd1);
    pix      = s_q[15:12];
    span     = {1'b0, tsr_xs} + 4'd1;

    tsr_rdy   = !run;
    dram_addr = {page_q + {5'b0, line_q[8:6]}, line_q[5:0], w_q};
    lbuf_addr = x_q;
    lbuf_we   = emit && (pix != 4'd0);
    lbuf_data = emit ? {pal_q, pix} : 8'd0;
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    line_d  = line_q;
    w_d     = w_q;
    xf_d    = xf_q;
    pal_d   = pal_q;
    wl_d    = wl_q;
    pl_d    = pl_q;
    x_d     = x_q;
    s_d     = s_q;
    sc_d    = sc_q;
    p_d     = p_q;
    pv_d    = pv_q;
    unique case (state_q)
      IDLE: begin
        if (tsr_go) begin
          state_d = RUN;
          page_d  = tsr_page;
          line_d  = tsr_line;
          xf_d    = tsr_xf;
          pal_d   = tsr_pal;
          x_d     = tsr_x;
          wl_d    = {span, 1'b0};
          pl_d    = {span, 3'b000};
          sc_d    = 3'd0;
          pv_d    = 1'b0;
          if (tsr_xf)
            w_d = {tsr_addr, 1'b1} + {3'b000, tsr_xs, 1'b0};
          else
            w_d = {tsr_addr, 1'b0};
        end
      end
      RUN: begin
        if (emit) begin
          s_d  = s_q << 4;
          sc_d = sc_q - 3'd1;
          x_d  = x_q + 9'd1;
          pl_d = pl_q - 7'd1;
          if (pl_q == 7'd1)
            state_d = IDLE;
          if ((sc_q == 3'd1) && pv_q) begin
            s_d  = p_q;
            sc_d = 3'd4;
            pv_d = 1'b0;
          end
        end
        // Grants only happen with P empty, so S and P never both load.
        if (grant) begin
          w_d  = xf_q ? w_q - 7'd1 : w_q + 7'd1;
          wl_d = wl_q - 5'd1;
          if (s_free) begin
            s_d  = seq;
            sc_d = 3'd4;
          end else begin
            p_d  = seq;
            pv_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= '0;
      line_q  <= '0;
      w_q     <= '0;
      xf_q    <= 1'b0;
      pal_q   <= '0;
      wl_q    <= '0;
      pl_q    <= '0;
      x_q     <= '0;
      s_q     <= '0;
      sc_q    <= '0;
      p_q     <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      line_q  <= line_d;
      w_q     <= w_d;
      xf_q    <= xf_d;
      pal_q   <= pal_d;
      wl_q    <= wl_d;
      pl_q    <= pl_d;
      x_q     <= x_d;
      s_q     <= s_d;
      sc_q    <= sc_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
    end
  end

endmodule
